// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the PS/2 lines, decodes
// 11-bit frames and queues good bytes in a first-word fall-through FIFO.
module ps2_kbd_rx #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FILTER_LEN     = 8,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic [4:0] count,
    output logic       overflow,
    output logic       parity_err,
    output logic       frame_err,
    input  logic       clr_err
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0] line_in;
    logic [1:0] line_sync;
    assign line_in = {ps2_dat_in, ps2_clk_in};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic s1_reg;
            logic s2_reg;
            always_ff @(posedge CLK) begin
                if (RST) begin
                    s1_reg <= 1'b1;
                    s2_reg <= 1'b1;
                end else begin
                    s1_reg <= line_in[gi];
                    s2_reg <= s1_reg;
                end
            end
            assign line_sync[gi] = s2_reg;
        end
    endgenerate

    logic sync_clk, sync_dat;
    assign sync_clk = line_sync[0];
    assign sync_dat = line_sync[1];

    // The filtered clock flips on the FILTER_LEN-th consecutive differing sample.
    logic          filt_clk_reg;
    logic [FW-1:0] filt_cnt_reg;
    logic          filt_flip;
    logic          fall_edge;
    assign filt_flip = (sync_clk != filt_clk_reg) && (filt_cnt_reg == FW'(FILTER_LEN - 1));
    assign fall_edge = filt_flip && filt_clk_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            filt_clk_reg <= 1'b1;
            filt_cnt_reg <= '0;
        end else if (sync_clk == filt_clk_reg) begin
            filt_cnt_reg <= '0;
        end else if (filt_flip) begin
            filt_clk_reg <= sync_clk;
            filt_cnt_reg <= '0;
        end else begin
            filt_cnt_reg <= filt_cnt_reg + FW'(1);
        end
    end

    state_t        state_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    shift_reg;
    logic          parity_reg;
    logic [TW-1:0] tmo_cnt_reg;
    logic          push_reg;
    logic [7:0]    push_data_reg;
    logic          parity_err_reg;
    logic          frame_err_reg;
    logic          odd_ones;
    assign odd_ones = ^{shift_reg, parity_reg};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= IDLE;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            parity_reg     <= 1'b0;
            tmo_cnt_reg    <= '0;
            push_reg       <= 1'b0;
            push_data_reg  <= '0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            push_reg <= 1'b0;
            // Clear first so a same-cycle set below takes priority.
            if (clr_err) begin
                parity_err_reg <= 1'b0;
                frame_err_reg  <= 1'b0;
            end
            if (state_reg == IDLE) begin
                tmo_cnt_reg <= '0;
                if (fall_edge && !sync_dat) begin
                    state_reg   <= DATA;
                    bit_idx_reg <= '0;
                end
            end else if (fall_edge) begin
                tmo_cnt_reg <= '0;
                case (state_reg)
                    DATA: begin
                        shift_reg   <= {sync_dat, shift_reg[7:1]};
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                        if (bit_idx_reg == 3'd7)
                            state_reg <= PARITY;
                    end
                    PARITY: begin
                        parity_reg <= sync_dat;
                        state_reg  <= STOP;
                    end
                    STOP: begin
                        state_reg <= IDLE;
                        if (sync_dat && odd_ones) begin
                            push_reg      <= 1'b1;
                            push_data_reg <= shift_reg;
                        end
                        if (!odd_ones)
                            parity_err_reg <= 1'b1;
                        if (!sync_dat)
                            frame_err_reg <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                state_reg     <= IDLE;
                tmo_cnt_reg   <= '0;
                frame_err_reg <= 1'b1;
            end else begin
                tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
            end
        end
    end

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [4:0]    count_reg;
    logic [7:0]    head_reg;
    logic          overflow_reg;
    logic          pop, full, push_ok;

    assign pop         = rd_en && (count_reg != 5'd0);
    assign full        = (count_reg == 5'(FIFO_DEPTH));
    assign push_ok     = push_reg && (!full || pop);
    assign rd_ptr_next = pop ? rd_ptr_reg + PW'(1) : rd_ptr_reg;

    always_ff @(posedge CLK) begin
        if (push_ok)
            mem[wr_ptr_reg] <= push_data_reg;
    end

    // head_reg is a registered read at the next head address, bypassing a same-cycle write there.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            head_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            rd_ptr_reg <= rd_ptr_next;
            if (push_ok && !pop)
                count_reg <= count_reg + 5'd1;
            else if (!push_ok && pop)
                count_reg <= count_reg - 5'd1;
            head_reg <= (push_ok && (wr_ptr_reg == rd_ptr_next)) ? push_data_reg : mem[rd_ptr_next];
            if (clr_err)
                overflow_reg <= 1'b0;
            if (push_reg && !push_ok)
                overflow_reg <= 1'b1;
        end
    end

    assign rd_data    = (count_reg == 5'd0) ? 8'h00 : head_reg;
    assign rd_valid   = (count_reg != 5'd0);
    assign count      = count_reg;
    assign overflow   = overflow_reg;
    assign parity_err = parity_err_reg;
    assign frame_err  = frame_err_reg;
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: drives PS/2 frames bit by bit and checks
// FIFO contents, occupancy and sticky flags with immediate assertions.
module tb_ps2_kbd_rx;
    localparam int HP  = 40;    // PS/2 half bit period in CLK cycles
    localparam int TMO = 1000;

    logic       CLK = 1'b0;
    logic       RST;
    logic       ps2_clk_in, ps2_dat_in, rd_en, clr_err;
    logic [7:0] rd_data;
    logic       rd_valid, overflow, parity_err, frame_err;
    logic [4:0] count;

    int n_assert = 0;
    int n_fail   = 0;

    ps2_kbd_rx #(.TIMEOUT_CYCLES(TMO), .FILTER_LEN(8), .FIFO_DEPTH(16)) dut (
        .CLK(CLK), .RST(RST), .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
        .overflow(overflow), .parity_err(parity_err), .frame_err(frame_err),
        .clr_err(clr_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int e_cnt, input int e_data,
                             input int e_ovf, input int e_par, input int e_frm);
        chk({tag, "_count"}, 32'(count), e_cnt);
        chk({tag, "_valid"}, 32'(rd_valid), (e_cnt != 0) ? 1 : 0);
        chk({tag, "_data"},  32'(rd_data), e_data);
        chk({tag, "_ovf"},   32'(overflow), e_ovf);
        chk({tag, "_par"},   32'(parity_err), e_par);
        chk({tag, "_frm"},   32'(frame_err), e_frm);
        $display("step %s: count=%0d rd_data=0x%02h ovf=%0b par=%0b frm=%0b",
                 tag, count, rd_data, overflow, parity_err, frame_err);
    endtask

    // hook 1: latency check, 2: pop on push cycle, 3: clr_err on flag-set cycle
    task automatic ps2_bit(input logic b, input bit glitch, input int hook);
        ps2_dat_in = b;
        if (glitch) begin
            repeat (10) @(negedge CLK);
            ps2_clk_in = 1'b0;
            repeat (3) @(negedge CLK);
            ps2_clk_in = 1'b1;
            repeat (HP - 13) @(negedge CLK);
        end else begin
            repeat (HP) @(negedge CLK);
        end
        ps2_clk_in = 1'b0;
        if (hook == 1) begin
            repeat (10) @(negedge CLK);
            chk("lat_before_push", 32'(count), 0);
            @(negedge CLK);
            chk("lat_after_push", 32'(count), 1);
            repeat (HP - 11) @(negedge CLK);
        end else if (hook == 2) begin
            repeat (10) @(negedge CLK);
            rd_en = 1'b1;
            @(negedge CLK);
            rd_en = 1'b0;
            repeat (HP - 11) @(negedge CLK);
        end else if (hook == 3) begin
            repeat (9) @(negedge CLK);
            clr_err = 1'b1;
            @(negedge CLK);
            clr_err = 1'b0;
            repeat (HP - 10) @(negedge CLK);
        end else begin
            repeat (HP) @(negedge CLK);
        end
        ps2_clk_in = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input logic stop,
                              input int nbits, input int glitch_bit, input int hook);
        logic [10:0] bits;
        bits = {stop, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++)
            ps2_bit(bits[i], i == glitch_bit, (i == 10) ? hook : 0);
        repeat (HP) @(negedge CLK);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge CLK);
        rd_en = 1'b0;
    endtask

    task automatic clear();
        clr_err = 1'b1;
        @(negedge CLK);
        clr_err = 1'b0;
    endtask

    initial begin
        RST = 1'b1; ps2_clk_in = 1'b1; ps2_dat_in = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        repeat (4) @(negedge CLK);
        chk_state("reset", 0, 0, 0, 0, 0);
        RST = 1'b0;

        // Reset mid-frame abandons it silently; no later timeout either.
        send_frame(8'h77, 0, 1, 5, -1, 0);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (TMO + 50) @(negedge CLK);
        chk_state("reset_midframe", 0, 0, 0, 0, 0);

        send_frame(8'h1C, 0, 1, 11, -1, 1);
        chk_state("good_1c", 1, 'h1C, 0, 0, 0);
        pop();
        chk_state("pop_1c", 0, 0, 0, 0, 0);
        pop();
        chk_state("pop_empty", 0, 0, 0, 0, 0);

        send_frame(8'hF0, 1, 1, 11, -1, 0);
        chk_state("bad_parity_f0", 0, 0, 0, 1, 0);
        send_frame(8'h0F, 1, 1, 11, -1, 3);
        chk_state("set_beats_clr", 0, 0, 0, 1, 0);
        clear();
        chk_state("clr_parity", 0, 0, 0, 0, 0);
        send_frame(8'h55, 0, 0, 11, -1, 0);
        chk_state("bad_stop_55", 0, 0, 0, 0, 1);
        clear();
        send_frame(8'h33, 1, 0, 11, -1, 0);
        chk_state("bad_both_33", 0, 0, 0, 1, 1);
        clear();
        chk_state("clr_both", 0, 0, 0, 0, 0);

        for (int i = 1; i <= 17; i++)
            send_frame(8'(i), 0, 1, 11, -1, 0);
        chk_state("overflow_fill", 16, 'h01, 1, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("drain_%0d", i), 32'(rd_data), i);
            pop();
        end
        chk_state("drained", 0, 0, 1, 0, 0);
        clear();
        chk_state("clr_ovf", 0, 0, 0, 0, 0);

        send_frame(8'h00, 0, 1, 4, -1, 0);
        chk_state("partial_no_tmo_yet", 0, 0, 0, 0, 0);
        repeat (TMO + 10) @(negedge CLK);
        chk_state("timeout", 0, 0, 0, 0, 1);
        send_frame(8'h5A, 0, 1, 11, -1, 0);
        chk_state("after_timeout_5a", 1, 'h5A, 0, 0, 1);
        pop();
        clear();

        for (int i = 0; i < 16; i++)
            send_frame(8'h20 + 8'(i), 0, 1, 11, -1, 0);
        chk_state("full_20", 16, 'h20, 0, 0, 0);
        send_frame(8'hAA, 0, 1, 11, -1, 2);
        chk_state("push_pop_full", 16, 'h21, 0, 0, 0);
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("drain_2x_%0d", i), 32'(rd_data), 'h21 + i);
            pop();
        end
        chk("last_is_aa", 32'(rd_data), 'hAA);
        pop();
        chk_state("drained_aa", 0, 0, 0, 0, 0);

        send_frame(8'h3C, 0, 1, 11, 4, 0);
        chk_state("glitch_3c", 1, 'h3C, 0, 0, 0);
        pop();
        chk_state("final", 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning the maximum number of CLK cycles allowed between filtered PS/2 clock falling edges inside a frame (2 ms at 50 MHz).
REQ-002 SHALL have parameter FILTER_LEN, default 8, meaning the number of consecutive equal synchronized samples needed to change the filtered PS/2 clock.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning the receive FIFO entry count (power of two).
REQ-004 SHALL have port CLK, input, 1 bit: the single system clock (50 MHz); all logic is on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: the reset, synchronous and active-high.
REQ-006 SHALL have port ps2_clk_in, input, 1 bit: asynchronous PS/2 clock line, sampled value of the top-level PS2_CLK.
REQ-007 SHALL have port ps2_dat_in, input, 1 bit: asynchronous PS/2 data line, sampled value of the top-level PS2_DAT.
REQ-008 SHALL have port rd_en, input, 1 bit: a CPU pop request for the FIFO head.
REQ-009 SHALL have port rd_data, output, 8 bits: the FIFO head byte (first-word fall-through).
REQ-010 SHALL have port rd_valid, output, 1 bit: high when the FIFO is not empty.
REQ-011 SHALL have port count, output, 5 bits: the current FIFO occupancy, 0..FIFO_DEPTH.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag, set when a received byte was dropped because the FIFO was full.
REQ-013 SHALL have port parity_err, output, 1 bit: sticky flag for a received frame with bad parity.
REQ-014 SHALL have port frame_err, output, 1 bit: sticky flag for a bad stop bit or a timeout.
REQ-015 SHALL have port clr_err, input, 1 bit: clears all three sticky flags.

Function
REQ-016 SHALL synchronize both PS/2 inputs through 2 flip-flops before any other use.
REQ-017 SHALL change the filtered clock only after FILTER_LEN consecutive equal synchronized clock samples; shorter pulses are ignored.
REQ-018 SHALL detect a falling edge as filtered clock 1->0 and sample the synchronized data bit on that cycle.
REQ-019 SHALL implement states IDLE, DATA, PARITY and STOP.
REQ-020 SHALL handle IDLE as follows: on a falling edge with data=0, go to DATA with bit index 0; with data=1, stay in IDLE and record no error.
REQ-021 SHALL handle DATA as follows: shift data in LSB first; after the 8th bit, go to PARITY.
REQ-022 SHALL handle PARITY as follows: capture the bit and go to STOP.
REQ-023 SHALL handle STOP as follows: on a falling edge, go to IDLE; the frame is good when stop=1 and the count of ones across the data and parity bits is odd.
REQ-024 SHALL push a good frame into the FIFO on the cycle after the stop-bit edge, so that rd_valid and count update 1 cycle after the stop edge is detected.
REQ-025 SHALL discard a frame with bad parity and set parity_err; a frame with stop=0 SHALL be discarded and set frame_err; when both occur, both flags SHALL be set.
REQ-026 SHALL count CLK cycles since the last falling edge in every state except IDLE; on reaching TIMEOUT_CYCLES it SHALL return to IDLE, discard partial data and set frame_err.
REQ-027 SHALL drop the byte and set overflow when pushing into a full FIFO (count=FIFO_DEPTH), leaving FIFO contents unchanged.
REQ-028 SHALL pop the head on rd_en with count>0, so that rd_data shows the next entry on the following cycle; rd_en while empty SHALL be ignored with no underflow.
REQ-029 SHALL perform both a push and a pop in the same cycle, leaving count unchanged; when full with a pop in the same cycle, the push SHALL be accepted and overflow SHALL NOT be set.
REQ-030 SHALL let a flag set event win when clr_err and the set event occur in the same cycle.
REQ-031 SHALL wrap the read and write pointers modulo FIFO_DEPTH, with count tracked separately.
REQ-032 SHALL drive rd_data as 8'h00 when the FIFO is empty.

Reset
REQ-033 SHALL, on RST=1 at a rising CLK edge, set the state to IDLE, the bit index and timeout counter to 0, the FIFO empty (count=0, rd_valid=0, rd_data=8'h00) and overflow/parity_err/frame_err to 0.
REQ-034 SHALL initialize the filter and synchronizer outputs to 1 (idle bus level) on reset.
REQ-035 SHALL abandon a frame in progress on reset without setting any flag.

Verification
REQ-036 SHALL pass this scenario: frame 0x1C (parity=0, stop=1) at a 12.5 kHz PS/2 clock -> count=1, rd_valid=1, rd_data=0x1C, no flags; then rd_en for 1 cycle -> count=0.
REQ-037 SHALL pass this scenario: frame 0xF0 with parity=0 (bad) -> parity_err=1, count=0; then clr_err -> parity_err=0.
REQ-038 SHALL pass this scenario: 17 good frames 0x01..0x11 with no reads -> count=16, overflow=1; 16 pops return 0x01..0x10 in order.
REQ-039 SHALL pass this scenario: start bit plus 3 data bits, then clock held high for 2.1 ms -> frame_err=1, state IDLE; the next frame 0x5A SHALL be received correctly.
REQ-040 SHALL pass this scenario: FIFO full, with rd_en asserted on the push cycle of frame 0xAA -> count stays 16, overflow=0, and 0xAA is the last entry.
REQ-041 SHALL pass this scenario: a 3-cycle low glitch on ps2_clk_in mid-frame -> no extra bit is shifted in, and the frame decodes correctly.
